// File: rtl/hamming_pkg.sv
// Shared definitions for the time-shared Hamming weight scheduler.
//   ham_state_e : scheduler FSM states
//   HAM_BYTE_W  : width of the shared combinational byte unit
//   popcount8   : number of set bits in one byte (0..8)
package hamming_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } ham_state_e;

    localparam int HAM_BYTE_W = 8;

    function automatic logic [3:0] popcount8(input logic [7:0] b);
        logic [3:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            cnt = cnt + 4'(b[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/hamming_byte_unit.sv
// Combinational byte Hamming unit: the single resource shared by all requesters.
//   data_in : byte to evaluate
//   weight  : number of 1 bits in data_in (0..8)
//   parity  : XOR of all bits of data_in
module hamming_byte_unit
    import hamming_pkg::*;
(
    input  logic [HAM_BYTE_W-1:0] data_in,
    output logic [3:0]            weight,
    output logic                  parity
);

    always_comb begin
        weight = popcount8(data_in);
        parity = ^data_in;
    end

endmodule

// File: rtl/hamming_rr_sched.sv
// Round-robin scheduler that streams each granted operand through one shared
// byte Hamming unit, one byte per cycle, and returns {id, weight, parity}.
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   req_valid   : per-requester request valid
//   req_data    : operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready   : one-hot grant, only ever set in IDLE
//   rsp_valid   : result valid (DONE state)
//   rsp_ready   : consumer accepts result
//   rsp_id      : index of the served requester
//   rsp_weight  : population count of the operand
//   rsp_parity  : XOR of all operand bits
module hamming_rr_sched
    import hamming_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*WIDTH-1:0]      req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NREQ)-1:0]    rsp_id,
    output logic [$clog2(WIDTH+1)-1:0] rsp_weight,
    output logic                       rsp_parity
);

    localparam int IDW    = $clog2(NREQ);
    localparam int AW     = $clog2(WIDTH + 1);
    localparam int NBYTES = WIDTH / HAM_BYTE_W;
    localparam int CNTW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    ham_state_e       state_q, state_d;
    logic [IDW-1:0]   rr_ptr;
    logic [WIDTH-1:0] shift_q;
    logic [CNTW-1:0]  cnt_q;
    logic [AW-1:0]    acc_q;
    logic             par_q;
    logic [IDW-1:0]   id_q;

    logic             grant_vld;
    logic [IDW-1:0]   grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic [3:0]       byte_weight;
    logic             byte_parity;
    logic [AW-1:0]    acc_sum;
    logic             last_byte;

    // Rotating-priority find-first: scan rr_ptr, rr_ptr+1, ... modulo NREQ.
    always_comb begin
        int unsigned idx;
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        idx        = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(rr_ptr) + k) % 32'(NREQ);
            if (!grant_vld && req_valid[idx]) begin
                grant_vld  = 1'b1;
                grant_idx  = IDW'(idx);
                grant_data = req_data[idx*WIDTH +: WIDTH];
            end
        end
    end

    hamming_byte_unit u_byte (
        .data_in (shift_q[HAM_BYTE_W-1:0]),
        .weight  (byte_weight),
        .parity  (byte_parity)
    );

    assign acc_sum   = acc_q + AW'(byte_weight);
    assign last_byte = (cnt_q == CNTW'(NBYTES - 1));
    assign rsp_valid = (state_q == DONE);
    assign req_ready = (state_q == IDLE && grant_vld) ? (NREQ'(1) << grant_idx) : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_vld) state_d = BUSY;
            BUSY:    if (last_byte) state_d = DONE;
            DONE:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            shift_q    <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            par_q      <= 1'b0;
            id_q       <= '0;
            rsp_id     <= '0;
            rsp_weight <= '0;
            rsp_parity <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        shift_q <= grant_data;
                        id_q    <= grant_idx;
                        acc_q   <= '0;
                        par_q   <= 1'b0;
                        cnt_q   <= '0;
                        rr_ptr  <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
                    end
                end
                BUSY: begin
                    shift_q <= shift_q >> HAM_BYTE_W;
                    acc_q   <= acc_sum;
                    par_q   <= par_q ^ byte_parity;
                    cnt_q   <= cnt_q + CNTW'(1);
                    // Result registers take the sum including the final byte,
                    // so they are already correct on the first DONE cycle.
                    if (last_byte) begin
                        rsp_id     <= id_q;
                        rsp_weight <= acc_sum;
                        rsp_parity <= par_q ^ byte_parity;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_rr_sched.sv
module tb_hamming_rr_sched;

    localparam int NREQ   = 4;
    localparam int WIDTH  = 32;
    localparam int NBYTES = WIDTH / 8;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_id;
    logic [5:0]            rsp_weight;
    logic                  rsp_parity;

    int n_vec  = 0;
    int n_fail = 0;

    hamming_rr_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_weight (rsp_weight),
        .rsp_parity (rsp_parity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic int first_valid(input int ptr, input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++)
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    int m_phase;   // 0 waiting for request, 1 computing, 2 holding result
    int m_ptr;
    int m_left;
    int m_id, m_w;
    int e_id, e_w, e_p;
    int m_g, m_gw;

    assign m_g  = first_valid(m_ptr, req_valid);
    assign m_gw = $countones(req_data[(m_g < 0 ? 0 : m_g)*WIDTH +: WIDTH]);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_ptr <= 0; m_left <= 0; m_id <= 0; m_w <= 0;
            e_id <= 0; e_w <= 0; e_p <= 0;
        end else begin
            case (m_phase)
                0: if (m_g >= 0) begin
                    m_id    <= m_g;
                    m_w     <= m_gw;
                    m_ptr   <= (m_g + 1) % NREQ;
                    m_left  <= NBYTES;
                    m_phase <= 1;
                end
                1: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_phase <= 2;
                        e_id <= m_id; e_w <= m_w; e_p <= m_w % 2;
                    end
                end
                default: if (rsp_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_ready;
        exp_ready = (m_phase == 0 && m_g >= 0) ? NREQ'(1 << m_g) : '0;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("rsp_valid", 64'(rsp_valid), 64'(m_phase == 2));
        check("rsp_id",    64'(rsp_id),    64'(e_id));
        check("rsp_weight",64'(rsp_weight),64'(e_w));
        check("rsp_parity",64'(rsp_parity),64'(e_p));
        check("onehot",    64'($countones(req_ready) <= 1), 64'(1));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_grant(input string nm, output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready != 0) begin ok = 1; break; end
        end
        if (!ok) check({nm, "_timeout"}, 64'(0), 64'(1));
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick(); n++;
            if (rsp_valid) return;
        end
        check("rsp_timeout", 64'(0), 64'(1));
    endtask

    // Serve one request end-to-end with literal expectations.
    task automatic run_one(input int idx, input logic [WIDTH-1:0] d,
                           input int exp_w, input int exp_p);
        bit ok;
        int n;
        rsp_ready = 1'b1;
        req_valid = NREQ'(1 << idx);
        req_data[idx*WIDTH +: WIDTH] = d;
        wait_grant("grant", ok);
        check("grant_idx", 64'(req_ready), 64'(1 << idx));
        tick();
        req_valid = '0;
        wait_rsp(n);
        check("latency", 64'(n), 64'(NBYTES));
        check("lit_id", 64'(rsp_id), 64'(idx));
        check("lit_weight", 64'(rsp_weight), 64'(exp_w));
        check("lit_parity", 64'(rsp_parity), 64'(exp_p));
        tick();
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        logic [NREQ-1:0]  snap;
        int grants[$];
        int order[5] = '{0, 1, 2, 3, 0};
        bit ok;
        int n;

        rst_n = 1'b0; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Reset while busy: in-flight op dropped, next request served normally.
        req_valid = 4'b0001;
        req_data[0 +: WIDTH] = 32'hFFFF_FFFF;
        wait_grant("rst_grant", ok);
        tick();
        req_valid = '0;
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(rsp_valid), 64'(0));
        check("midrst_ready", 64'(req_ready), 64'(0));
        check("midrst_id", 64'(rsp_id), 64'(0));
        check("midrst_weight", 64'(rsp_weight), 64'(0));
        check("midrst_parity", 64'(rsp_parity), 64'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        d = $urandom;
        run_one(1, d, $countones(d), $countones(d) % 2);     // ptr -> 2

        run_one(2, 32'h8000_0001, 2, 0);                     // ptr -> 3
        run_one(0, 32'h0000_0000, 0, 0);                     // ptr -> 1
        run_one(3, 32'hFFFF_FFFF, 32, 0);                    // ptr -> 0
        run_one(0, 32'h0000_0007, 3, 1);                     // ptr -> 1
        d = $urandom;
        run_one(3, d, $countones(d), $countones(d) % 2);     // ptr -> 0

        // Round-robin with all four requesters continuously valid.
        for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = $urandom;
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 100 && grants.size() < 5; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) grants.push_back(i);
        end
        tick();
        req_valid = '0;
        check("rr_count", 64'(grants.size()), 64'(5));
        for (int i = 0; i < 5 && i < grants.size(); i++)
            check("rr_order", 64'(grants[i]), 64'(order[i]));
        repeat (NBYTES + 3) tick();                          // ptr -> 1

        // Backpressure in DONE with a second requester waiting.
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        req_data[1*WIDTH +: WIDTH] = $urandom;
        wait_grant("bp_grant", ok);
        tick();
        req_valid = 4'b0001;
        req_data[0 +: WIDTH] = $urandom;
        wait_rsp(n);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 64'(rsp_valid), 64'(1));
            check("bp_nogrant", 64'(req_ready), 64'(0));
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_release_valid", 64'(rsp_valid), 64'(0));
        check("bp_next_grant", 64'(req_ready), 64'(4'b0001));
        tick();
        req_valid = '0;
        repeat (NBYTES + 3) tick();                          // ptr -> 1

        // Skip and wrap: get ptr to 3, then only req1 valid.
        d = $urandom;
        run_one(2, d, $countones(d), $countones(d) % 2);     // ptr -> 3
        d = $urandom;
        run_one(1, d, $countones(d), $countones(d) % 2);     // ptr -> 2
        req_valid = '1;
        wait_grant("wrap_grant", ok);
        check("wrap_ptr", 64'(req_ready), 64'(4'b0100));
        tick();
        req_valid = '0;
        repeat (NBYTES + 3) tick();

        // Randomized traffic; the model checks every cycle.
        snap = '0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            snap = req_ready;
            @(posedge clk); #1;
            rsp_ready = ($urandom % 3) != 0;
            for (int i = 0; i < NREQ; i++) begin
                if (snap[i]) begin
                    req_valid[i] = $urandom % 2;
                    req_data[i*WIDTH +: WIDTH] = $urandom;
                end else if (req_valid[i]) begin
                    if ($urandom % 16 == 0) req_valid[i] = 1'b0;
                end else if ($urandom % 3 == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[i*WIDTH +: WIDTH] = ($urandom % 4 == 0) ? '1 : WIDTH'($urandom);
                end
            end
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (NBYTES + 4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
